// File: rtl/branch_resolver.sv
// Conditional-branch resolver: holds the architectural flags, counts in-flight compares,
// stalls branches until their flags arrive, and returns a registered taken/redirect result.
//
// state  | meaning
// S_IDLE | no branch waiting, no result this cycle
// S_WAIT | branch presented but its flags are still in flight
// S_DONE | a branch was accepted last cycle; resolve_valid is high
module branch_resolver #(
    parameter  int ADDR_W   = 32,
    parameter  int MAX_PEND = 3,
    localparam int CNT_W    = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmp_issue,
    output logic              cmp_ready,
    input  logic              flag_valid,
    input  logic [3:0]        flag_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              resolve_valid,
    output logic              resolve_taken,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [3:0]        flags_q,
    output logic [CNT_W-1:0]  pend_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    pend_q;
    logic [CNT_W-1:0]    pend_d;
    logic                taken_q;
    logic [ADDR_W-1:0]   redirect_q;
    logic                cmp_inc;
    logic                cmp_dec;
    logic                fresh;
    logic                br_accept;
    logic                eff_n;
    logic                eff_z;
    logic                eff_v;
    logic                cond_true;

    assign cmp_ready = (pend_q != CNT_W'(MAX_PEND));
    assign cmp_inc   = cmp_issue && cmp_ready;
    assign cmp_dec   = flag_valid && (pend_q != '0);

    // A single outstanding compare whose flags land this cycle counts as fresh,
    // unless another compare is issued alongside and will overwrite them.
    assign fresh     = (pend_q == '0) ||
                       ((pend_q == CNT_W'(1)) && flag_valid && !cmp_issue);
    assign br_ready  = fresh;
    assign br_accept = br_valid && br_ready;

    assign eff_n = flag_valid ? flag_in[0] : flags_q[0];
    assign eff_z = flag_valid ? flag_in[1] : flags_q[1];
    assign eff_v = flag_valid ? flag_in[3] : flags_q[3];

    always_comb begin
        pend_d = pend_q;
        if (cmp_inc && !cmp_dec) begin
            pend_d = pend_q + CNT_W'(1);
        end else if (cmp_dec && !cmp_inc) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'd0:    cond_true = eff_z;
            3'd1:    cond_true = !eff_z;
            3'd2:    cond_true = eff_n ^ eff_v;
            3'd3:    cond_true = !(eff_n ^ eff_v);
            3'd4:    cond_true = !eff_z && !(eff_n ^ eff_v);
            3'd5:    cond_true = eff_z || (eff_n ^ eff_v);
            3'd6:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0;
            pend_q  <= '0;
        end else begin
            if (flag_valid) begin
                flags_q <= flag_in;
            end
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            taken_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            if (br_accept) begin
                taken_q <= cond_true;
                if (cond_true) begin
                    redirect_q <= br_target;
                end
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (br_accept)     state_q <= S_DONE;
                    else if (br_valid) state_q <= S_WAIT;
                    else               state_q <= S_IDLE;
                end
                S_WAIT: begin
                    if (br_accept)      state_q <= S_DONE;
                    else if (!br_valid) state_q <= S_IDLE;
                    else                state_q <= S_WAIT;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign resolve_valid = (state_q == S_DONE);
    assign resolve_taken = taken_q;
    assign redirect_pc   = redirect_q;
    assign pend_cnt      = pend_q;

endmodule
